// File: rtl/select_scan_pkg.sv
// select_scan_pkg
//   Shared definitions for the select-memory scan reader: default address
//   width and depth of the position select memory, plus the scan FSM state
//   encoding used by select_scan_reader.
//   No ports (package).
package select_scan_pkg;

  localparam int SCAN_ADDR_W = 8;
  localparam int SCAN_DEPTH  = 1 << SCAN_ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    ISSUE,
    DRAIN,
    DONE
  } scan_state_t;

endpackage

// File: rtl/select_scan_if.sv
// select_scan_if
//   Read bus between the scan reader (master) and the position select
//   memory (slave). The memory answers every rd_en with one data_in bit,
//   qualified by data_in_valid, exactly one cycle later.
//   Signals:
//     rd_ready       memory -> reader  reads are legal while high
//     rd_en          reader -> memory  read strobe, one address per cycle
//     rd_addr        reader -> memory  read address, valid with rd_en
//     data_in        memory -> reader  mask bit returned
//     data_in_valid  memory -> reader  qualifies data_in
interface select_scan_if #(
  parameter int ADDR_W = select_scan_pkg::SCAN_ADDR_W
);
  logic              rd_ready;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              data_in;
  logic              data_in_valid;

  modport master (
    input  rd_ready, data_in, data_in_valid,
    output rd_en, rd_addr
  );

  modport slave (
    output rd_ready, data_in, data_in_valid,
    input  rd_en, rd_addr
  );
endinterface

// File: rtl/select_run_tracker.sv
// select_run_tracker
//   Receive side of the scan: counts returned bits (the count, not the read
//   address, labels each bit) and tracks the first contiguous run of 1s.
//   Build option: SELECT_SCAN_EARLY_STOP_EN defined -> multi_run stays 0.
//   Ports:
//     clk, rst    clock, synchronous active-high reset
//     clear       restart tracking for a new scan
//     bit_valid   a returned bit is accepted this cycle
//     bit_data    value of that bit
//     rx_count    number of bits received (terminal at DEPTH, never wraps)
//     run_open    first run started and not yet closed
//     win_found   at least one set bit seen
//     win_start   address of the first set bit
//     win_end     last address of the first run (inclusive)
//     multi_run   a set bit seen after the first run closed
module select_run_tracker
  import select_scan_pkg::*;
#(
  parameter int ADDR_W = SCAN_ADDR_W,
  parameter int DEPTH  = SCAN_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              bit_valid,
  input  logic              bit_data,
  output logic [ADDR_W:0]   rx_count,
  output logic              run_open,
  output logic              win_found,
  output logic [ADDR_W-1:0] win_start,
  output logic [ADDR_W-1:0] win_end,
  output logic              multi_run
);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DEPTH);

  logic              run_closed;
  logic [ADDR_W-1:0] bit_addr;

  assign bit_addr = rx_count[ADDR_W-1:0];
  assign run_open = win_found && !run_closed;

  // The extra counter bit lets a full mask end at DEPTH instead of wrapping
  // back to 0 and relabelling the last bit.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rx_count   <= '0;
      run_closed <= 1'b0;
      win_found  <= 1'b0;
      win_start  <= '0;
      win_end    <= '0;
      multi_run  <= 1'b0;
    end else if (bit_valid) begin
      if (rx_count != TERMINAL) begin
        rx_count <= rx_count + 1'b1;
      end
      if (bit_data) begin
        if (!win_found) begin
          win_found <= 1'b1;
          win_start <= bit_addr;
          win_end   <= bit_addr;
        end else if (!run_closed) begin
          win_end <= bit_addr;
        end else begin
`ifndef SELECT_SCAN_EARLY_STOP_EN
          multi_run <= 1'b1;
`endif
        end
      end else if (win_found) begin
        run_closed <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/select_scan_reader.sv
// select_scan_reader
//   Read-side initiator for the position select memory. On scan_start it
//   reads addresses 0..DEPTH-1, consumes the returned bit stream and reports
//   the first selected window as (win_start, win_end).
//   Build option: SELECT_SCAN_EARLY_STOP_EN defined -> stop issuing reads as
//   soon as the first run closes; multi_run is then always 0.
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     scan_start   1-cycle request, accepted only when idle
//     mem          select_scan_if master: rd_ready/rd_en/rd_addr/data_in/
//                  data_in_valid
//     busy         scan in progress (accepted request until done)
//     done         1-cycle completion pulse
//     win_found, win_start, win_end, multi_run   window results
//     aborted      rd_ready fell during the scan; window results invalid
module select_scan_reader
  import select_scan_pkg::*;
#(
  parameter int ADDR_W = SCAN_ADDR_W,
  parameter int DEPTH  = SCAN_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_start,
  select_scan_if.master     mem,
  output logic              busy,
  output logic              done,
  output logic              win_found,
  output logic [ADDR_W-1:0] win_start,
  output logic [ADDR_W-1:0] win_end,
  output logic              multi_run,
  output logic              aborted
);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(DEPTH - 1);

  scan_state_t      state;
  scan_state_t      state_next;
  logic [CNT_W-1:0] issue_count;
  logic [CNT_W-1:0] rx_count;
  logic             rd_en;
  logic             start_accept;
  logic             scanning;
  logic             abort_now;
  logic             bit_valid;
  logic             early_stop;
  logic             run_open;

  assign start_accept = (state == IDLE) && scan_start;
  assign scanning     = (state == ISSUE) || (state == DRAIN);
  assign abort_now    = scanning && !mem.rd_ready;
  // A bit arriving in the same cycle rd_ready drops is the in-flight one
  // being discarded by the abort.
  assign bit_valid    = scanning && mem.rd_ready && mem.data_in_valid;

`ifdef SELECT_SCAN_EARLY_STOP_EN
  // The closing 0 is seen while the next read would go out, so suppressing
  // that read leaves nothing outstanding.
  assign early_stop = bit_valid && !mem.data_in && run_open;
`else
  assign early_stop = 1'b0;
`endif

  assign mem.rd_en   = rd_en;
  assign mem.rd_addr = issue_count[ADDR_W-1:0];
  assign busy        = (state == WAIT_RDY) || scanning;
  assign done        = (state == DONE);

  // Next-state and read strobe. DRAIN ends on the last returned bit, or
  // immediately when every issued read has already come back.
  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    case (state)
      IDLE: begin
        if (scan_start) state_next = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (mem.rd_ready) state_next = ISSUE;
      end
      ISSUE: begin
        if (abort_now) begin
          state_next = DONE;
        end else if (early_stop) begin
          state_next = DRAIN;
        end else begin
          rd_en = 1'b1;
          if (issue_count == LAST_ADDR) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (abort_now || mem.data_in_valid || (rx_count == issue_count)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register, issue counter and sticky abort flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      issue_count <= '0;
      aborted     <= 1'b0;
    end else begin
      state <= state_next;
      if (start_accept) begin
        issue_count <= '0;
        aborted     <= 1'b0;
      end else begin
        if (rd_en) issue_count <= issue_count + 1'b1;
        if (abort_now) aborted <= 1'b1;
      end
    end
  end

  select_run_tracker #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_tracker (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_accept),
    .bit_valid(bit_valid),
    .bit_data (mem.data_in),
    .rx_count (rx_count),
    .run_open (run_open),
    .win_found(win_found),
    .win_start(win_start),
    .win_end  (win_end),
    .multi_run(multi_run)
  );

endmodule

// File: tb/tb_select_scan_reader.sv
// tb_select_scan_reader
//   Scoreboard bench for select_scan_reader. Each scan pushes its hand-
//   computed expectation; a monitor pops and compares on every done pulse.
//   Build option: SELECT_SCAN_EARLY_STOP_EN selects early-stop expectations.
module tb_select_scan_reader;
  import select_scan_pkg::*;

  typedef struct {
    logic found;
    int   start;
    int   fin;
    logic multi;
    logic abrt;
    logic check_win;
    int   reads;
    int   last;
    int   latency;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scan_start = 1'b0;
  logic       busy, done, win_found, multi_run, aborted;
  logic [7:0] win_start, win_end;
  logic [255:0] mask = '0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int reads = 0;
  int last_addr = 0;
  exp_t exp_q[$];

  select_scan_if #(.ADDR_W(8)) bus ();

  select_scan_reader #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk       (clk),
    .rst       (rst),
    .scan_start(scan_start),
    .mem       (bus),
    .busy      (busy),
    .done      (done),
    .win_found (win_found),
    .win_start (win_start),
    .win_end   (win_end),
    .multi_run (multi_run),
    .aborted   (aborted)
  );

  always #5 clk = ~clk;

  // Memory model: one-cycle read latency.
  always @(posedge clk) begin
    if (rst) begin
      bus.data_in_valid <= 1'b0;
      bus.data_in       <= 1'b0;
    end else begin
      bus.data_in_valid <= bus.rd_en;
      bus.data_in       <= mask[bus.rd_addr];
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic exp_t mkExp(input logic found, input int start, input int fin,
                                 input logic multi, input logic abrt, input logic check_win,
                                 input int rd_cnt, input int last, input int latency);
    exp_t e;
    e.found = found; e.start = start; e.fin = fin; e.multi = multi; e.abrt = abrt;
    e.check_win = check_win; e.reads = rd_cnt; e.last = last; e.latency = latency;
    return e;
  endfunction

  // Monitor: counts reads per scan and scores each done pulse.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      reads = 0;
      last_addr = 0;
    end else begin
      if (scan_start && !busy && !done) start_cyc = cyc;
      if (bus.rd_en) begin
        reads++;
        last_addr = int'(bus.rd_addr);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got done=1, expected no done");
        end else begin
          e = exp_q.pop_front();
          checkOutput("aborted", int'(aborted), int'(e.abrt));
          checkOutput("busy_at_done", int'(busy), 0);
          checkOutput("read_count", reads, e.reads);
          checkOutput("last_rd_addr", last_addr, e.last);
          if (e.check_win) begin
            checkOutput("win_found", int'(win_found), int'(e.found));
            checkOutput("win_start", int'(win_start), e.start);
            checkOutput("win_end", int'(win_end), e.fin);
            checkOutput("multi_run", int'(multi_run), int'(e.multi));
          end
          if (e.latency >= 0) checkOutput("done_latency", cyc - start_cyc, e.latency);
        end
        reads = 0;
      end
    end
  end

  task automatic pulseStart();
    @(posedge clk); #1 scan_start = 1'b1;
    @(posedge clk); #1 scan_start = 1'b0;
  endtask

  task automatic waitDone(input string name);
    bit seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got no done, expected done within 2000 cycles", name);
    end
  endtask

  task automatic applyStimulus(input string name, input logic [255:0] m, input exp_t e,
                               input int abort_at);
    bit seen = 0;
    mask = m;
    exp_q.push_back(e);
    pulseStart();
    if (abort_at >= 0) begin
      for (int i = 0; i < 2000 && !seen; i++) begin
        @(negedge clk);
        if (bus.rd_en && int'(bus.rd_addr) == abort_at - 1) seen = 1;
      end
      if (!seen) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s_abort_point: got no read at %0d, expected one", name, abort_at - 1);
      end
      @(posedge clk); #1 bus.rd_ready = 1'b0;
    end
    waitDone(name);
    @(posedge clk); #1 bus.rd_ready = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    logic [255:0] m;
    bus.rd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_rd_en", int'(bus.rd_en), 0);
    checkOutput("reset_rd_addr", int'(bus.rd_addr), 0);
    checkOutput("reset_win_found", int'(win_found), 0);
    checkOutput("reset_aborted", int'(aborted), 0);

    // Window 10..20
    m = '0; m[20:10] = '1;
    applyStimulus("win_10_20", m, mkExp(1, 10, 20, 0, 0, 1, 256, 255, 259), -1);

    // Empty mask: full scan in both builds
    m = '0;
    applyStimulus("empty", m, mkExp(0, 0, 0, 0, 0, 1, 256, 255, 259), -1);

    // Two runs 5..7 and 40..41
    m = '0; m[7:5] = '1; m[41:40] = '1;
`ifdef SELECT_SCAN_EARLY_STOP_EN
    applyStimulus("two_runs", m, mkExp(1, 5, 7, 0, 0, 1, 9, 8, -1), -1);
`else
    applyStimulus("two_runs", m, mkExp(1, 5, 7, 1, 0, 1, 256, 255, 259), -1);
`endif

    // Full mask: end at 255 with no wrap; multi_run cleared from previous scan
    m = '1;
    applyStimulus("full", m, mkExp(1, 0, 255, 0, 0, 1, 256, 255, 259), -1);

    // Single bits at both ends of the address range
    m = '0; m[0] = 1'b1; m[255] = 1'b1;
`ifdef SELECT_SCAN_EARLY_STOP_EN
    applyStimulus("ends", m, mkExp(1, 0, 0, 0, 0, 1, 2, 1, -1), -1);
`else
    applyStimulus("ends", m, mkExp(1, 0, 0, 1, 0, 1, 256, 255, 259), -1);
`endif

    // rd_ready drops where address 100 would be issued
    m = '0; m[20:10] = '1;
    applyStimulus("abort", m, mkExp(0, 0, 0, 0, 1, 0, 100, 99, -1), 100);

    // Same window again: aborted must be cleared by the new request
    applyStimulus("after_abort", m, mkExp(1, 10, 20, 0, 0, 1, 256, 255, 259), -1);

    // Repeated scan_start while busy and in the DONE cycle are ignored
    m = '0; m[63:60] = '1;
    mask = m;
    exp_q.push_back(mkExp(1, 60, 63, 0, 0, 1, 256, 255, 259));
    pulseStart();
    repeat (50) @(posedge clk);
    pulseStart();
    waitDone("busy_restart");
    scan_start = 1'b1;
    @(posedge clk); #1 scan_start = 1'b0;
    @(negedge clk);
    checkOutput("start_in_done_busy", int'(busy), 0);
    checkOutput("start_in_done_done", int'(done), 0);

    // Reset mid-scan: outputs return to 0 and no done pulse follows
    m = '1;
    mask = m;
    pulseStart();
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_busy", int'(busy), 0);
    checkOutput("rst_mid_done", int'(done), 0);
    checkOutput("rst_mid_rd_en", int'(bus.rd_en), 0);
    checkOutput("rst_mid_win_found", int'(win_found), 0);
    checkOutput("rst_mid_win_start", int'(win_start), 0);
    checkOutput("rst_mid_win_end", int'(win_end), 0);
    checkOutput("rst_mid_multi_run", int'(multi_run), 0);
    checkOutput("rst_mid_aborted", int'(aborted), 0);
    repeat (300) @(posedge clk);
    checkOutput("pending_expectations", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
